// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: DEPTH-entry FWFT FIFO with sticky overflow/framing flags (err_count under UART_RX_FIFO_ERR_COUNT_EN).
// Latency: a word captured at edge N is presented on out_valid/out_data after edge N; no combinational rx_* -> out_* path.
// Backpressure: out_valid/out_data hold while out_ready=0; when full a good word is dropped unless a pop frees its slot that cycle.
module uart_rx_fifo #(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_ready,
    input  logic                     rx_success,
    input  logic [BIT_WIDTH-1:0]     rx_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BIT_WIDTH-1:0]     out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     frame_err,
`ifdef UART_RX_FIFO_ERR_COUNT_EN
    output logic [7:0]               err_count,
`endif
    input  logic                     clear_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;

    logic good_frame;
    logic bad_frame;
    logic full;
    logic push;
    logic pop;
    logic drop;

    always_comb begin
        good_frame = rx_ready & rx_success;
        bad_frame  = rx_ready & ~rx_success;
        full       = (level == LW'(DEPTH));
        pop        = out_valid & out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push       = good_frame & (~full | pop);
        drop       = good_frame & full & ~pop;
    end

    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky flags: a set condition in the same cycle as clear_flags wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
            if (bad_frame) begin
                frame_err <= 1'b1;
            end else if (clear_flags) begin
                frame_err <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_ERR_COUNT_EN
    // Framing error and overflow drop are mutually exclusive, so at most +1 per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (bad_frame | drop) begin
            if (clear_flags) begin
                err_count <= 8'd1;
            end else if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end else if (clear_flags) begin
            err_count <= 8'd0;
        end
    end
`endif

endmodule
